pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
//  Program counter plus N-level return-address stack in one block. It replaces the fixed 12-bit/3-level pc + stack pair in the CPU top.
//  Depth, address width and overflow mode are parameters. Adds circular (4004-style) overflow, sticky error flags and defined same-cycle command priority.
//  Driven by decoder/microcycle strobes (pcIncPulse, jump, call, return); feeds pcAddr to ROM.
// PARAMETERS
//  ADDR_W    12  PC/stack entry width in bits
//  DEPTH     3   return-stack levels (>=2)
//  WRAP_MODE 1   1: circular overwrite on push-when-full; 0: refuse push and flag
//  RST_PC    0   PC value loaded by reset
// PORTS
//  clk         in  1       rising-edge clock
//  rst         in  1       asynchronous, active-high reset
//  inc         in  1       PC <= PC+1 (mod 2^ADDR_W)
//  load        in  1       jump: PC <= target
//  call        in  1       push return address, PC <= target
//  ret         in  1       pop: PC <= top entry
//  target      in  ADDR_W  jump/call destination
//  errClr      in  1       clears sticky overflow/underflow/conflict
//  pcAddr      out ADDR_W  current PC (registered)
//  stackTop    out ADDR_W  entry that ret would load (combinational)
//  level       out $clog2(DEPTH+1)  valid entries, 0..DEPTH
//  full        out 1       level==DEPTH
//  empty       out 1       level==0
//  overflow    out 1       sticky: push attempted while full
//  underflow   out 1       sticky: pop attempted while empty
//  conflict    out 1       sticky: call and ret in same cycle
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-command): pcAddr=RST_PC, level=0, ptr=0, all flags 0, stack contents 0. First command accepted on the first clk edge after rst deasserts.
//  - All updates at posedge clk, single-cycle latency; pcAddr/level reflect the command on the next cycle.
//  - Command priority per cycle: (call&ret) > ret > call > load > inc.
//    call&ret: no PC/stack change, conflict<=1.
//    ret: inc/load ignored. call: load ignored; return address = inc ? PC+1 : PC.
//    load: inc ignored.
//  - Push: entry[ptr]<=retAddr, ptr<=(ptr+1) mod DEPTH, level<=level+1.
//  - Pop: ptr<=(ptr-1) mod DEPTH, PC<=entry[ptr-1], level<=level-1. stackTop=entry[(ptr-1) mod DEPTH].
//  - Push when full, WRAP_MODE=1: oldest entry overwritten (ptr wraps), level stays DEPTH, PC<=target, overflow<=1.
//  - Push when full, WRAP_MODE=0: no write, ptr/level unchanged, PC<=target, overflow<=1.
//  - Pop when empty, WRAP_MODE=1: pop proceeds (stale entry loaded, ptr wraps), level stays 0, underflow<=1.
//  - Pop when empty, WRAP_MODE=0: PC, ptr and level unchanged; underflow<=1.
//  - PC+1 wraps from 2^ADDR_W-1 to 0 silently.
//  - errClr clears all three flags; a new error in the same cycle wins (flag stays 1).
// STRUCTURE
//  - Shared package: PC_W default, STACK_DEPTH default, WRAP/SATURATE mode constants, cmd-priority encoding.
//  - Sub-module lifo_ring: storage array + ptr/level counters + full/empty.
//  - Top holds the PC register, command priority mux and sticky flags.
// TESTING (DEPTH=3, ADDR_W=12 unless noted)
//  1. rst=1 mid-call -> pcAddr=0x000, level=0, flags 0; 5x inc -> pcAddr=0x005.
//  2. PC=0x0FF, inc=1, call=1, target=0x200 -> pcAddr=0x200, stackTop=0x100, level=1; ret -> pcAddr=0x100, empty=1.
//  3. WRAP_MODE=1: calls from PCs 0x010,0x020,0x030,0x040 -> overflow=1, level=3; 3 rets -> PCs 0x040,0x030,0x020.
//  4. WRAP_MODE=0: same calls -> 4th push dropped, overflow=1, PC=target; rets -> 0x030,0x020,0x010.
//  5. empty, ret=1: WRAP_MODE=0 -> PC held, underflow=1; errClr -> underflow=0.
//  6. call=1, ret=1 together -> PC and level unchanged, conflict=1; load+inc with target 0xABC -> pcAddr=0xABC.

Source files
------------

// File: rtl/pc_stack_unit_pkg.sv
// Shared constants and command encoding for the program counter and
// return-address stack block.
package pc_stack_unit_pkg;

    localparam int PC_W          = 12;
    localparam int STACK_DEPTH   = 3;
    localparam int MODE_SATURATE = 0;
    localparam int MODE_WRAP     = 1;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INC,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET,
        CMD_CONFLICT
    } cmd_e;

    // Same-cycle strobes collapse to one command, highest priority first.
    function automatic cmd_e decodeCmd(
        input logic inc,
        input logic load,
        input logic call,
        input logic ret
    );
        cmd_e cmd;
        cmd = CMD_NONE;
        if (call && ret)
            cmd = CMD_CONFLICT;
        else if (ret)
            cmd = CMD_RET;
        else if (call)
            cmd = CMD_CALL;
        else if (load)
            cmd = CMD_LOAD;
        else if (inc)
            cmd = CMD_INC;
        return cmd;
    endfunction

endpackage

// File: rtl/pc_stack_unit_lifo_ring.sv
// Circular return-address storage with pointer and fill-level tracking.
// In wrap mode pushes and pops proceed past the full/empty limits.
module lifo_ring
    import pc_stack_unit_pkg::*;
#(
    parameter int ADDR_W    = PC_W,
    parameter int DEPTH     = STACK_DEPTH,
    parameter int WRAP_MODE = MODE_WRAP,
    localparam int LVL_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] wrData,
    output logic [ADDR_W-1:0] rdData,
    output logic              canPop,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptrInc;
    logic [PTR_W-1:0]  ptrDec;
    logic [LVL_W-1:0]  lvl;
    logic              wrEn;
    logic              rdEn;

    assign ptrInc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign ptrDec = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - 1'b1;

    assign full   = (lvl == LVL_W'(DEPTH));
    assign empty  = (lvl == '0);
    assign level  = lvl;
    assign rdData = mem[ptrDec];

    assign canPop = !empty || (WRAP_MODE != 0);
    assign wrEn   = push && (!full || (WRAP_MODE != 0));
    assign rdEn   = pop && canPop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            lvl <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wrEn) begin
            mem[ptr] <= wrData;
            ptr      <= ptrInc;
            if (!full)
                lvl <= lvl + 1'b1;
        end else if (rdEn) begin
            ptr <= ptrDec;
            if (!empty)
                lvl <= lvl - 1'b1;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with an N-level return-address stack, command priority
// resolution and sticky overflow/underflow/conflict flags.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
#(
    parameter int              ADDR_W    = PC_W,
    parameter int              DEPTH     = STACK_DEPTH,
    parameter int              WRAP_MODE = MODE_WRAP,
    parameter logic [ADDR_W-1:0] RST_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    input  logic                         load,
    input  logic                         call,
    input  logic                         ret,
    input  logic [ADDR_W-1:0]            target,
    input  logic                         errClr,
    output logic [ADDR_W-1:0]            pcAddr,
    output logic [ADDR_W-1:0]            stackTop,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         conflict
);

    cmd_e              cmd;
    logic [ADDR_W-1:0] pcPlus1;
    logic [ADDR_W-1:0] retAddr;
    logic [ADDR_W-1:0] pcNext;
    logic              canPop;

    assign cmd     = decodeCmd(inc, load, call, ret);
    assign pcPlus1 = pcAddr + 1'b1;
    assign retAddr = inc ? pcPlus1 : pcAddr;

    lifo_ring #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) uRing (
        .clk    (clk),
        .rst    (rst),
        .push   (cmd == CMD_CALL),
        .pop    (cmd == CMD_RET),
        .wrData (retAddr),
        .rdData (stackTop),
        .canPop (canPop),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        pcNext = pcAddr;
        unique case (cmd)
            CMD_RET:  if (canPop) pcNext = stackTop;
            CMD_CALL: pcNext = target;
            CMD_LOAD: pcNext = target;
            CMD_INC:  pcNext = pcPlus1;
            default:  pcNext = pcAddr;
        endcase
    end

    // A fresh error in the same cycle as errClr keeps its flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcAddr    <= RST_PC;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            pcAddr    <= pcNext;
            overflow  <= (overflow && !errClr) || (cmd == CMD_CALL && full);
            underflow <= (underflow && !errClr) || (cmd == CMD_RET && empty);
            conflict  <= (conflict && !errClr) || (cmd == CMD_CONFLICT);
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomised and directed bench for pc_stack_unit, running a wrap-mode and a
// saturate-mode instance side by side against a behavioural model.
module tb_pc_stack_unit;

    localparam int AW = 12;
    localparam int D  = 3;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inc = 1'b0;
    logic          load = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          errClr = 1'b0;
    logic [AW-1:0] target = '0;

    logic [AW-1:0] pcW, topW, pcS, topS;
    logic [LW-1:0] lvlW, lvlS;
    logic          fullW, emptyW, ovW, unW, cfW;
    logic          fullS, emptyS, ovS, unS, cfS;

    int checks = 0;
    int failures = 0;

    // model state, index 0 = saturate, 1 = wrap
    int mPc [2];
    int mLvl[2];
    int mPtr[2];
    int mMem[2][D];
    bit mOv [2];
    bit mUn [2];
    bit mCf [2];

    always #5 clk = ~clk;

    pc_stack_unit #(.ADDR_W(AW), .DEPTH(D), .WRAP_MODE(1), .RST_PC('0)) dutW (
        .clk(clk), .rst(rst), .inc(inc), .load(load), .call(call), .ret(ret),
        .target(target), .errClr(errClr), .pcAddr(pcW), .stackTop(topW),
        .level(lvlW), .full(fullW), .empty(emptyW), .overflow(ovW),
        .underflow(unW), .conflict(cfW)
    );

    pc_stack_unit #(.ADDR_W(AW), .DEPTH(D), .WRAP_MODE(0), .RST_PC('0)) dutS (
        .clk(clk), .rst(rst), .inc(inc), .load(load), .call(call), .ret(ret),
        .target(target), .errClr(errClr), .pcAddr(pcS), .stackTop(topS),
        .level(lvlS), .full(fullS), .empty(emptyS), .overflow(ovS),
        .underflow(unS), .conflict(cfS)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mPc[m] = 0; mLvl[m] = 0; mPtr[m] = 0;
            mOv[m] = 0; mUn[m] = 0; mCf[m] = 0;
            for (int i = 0; i < D; i++) mMem[m][i] = 0;
        end
    endtask

    task automatic modelStep();
        for (int m = 0; m < 2; m++) begin
            bit wrap, ov, un, cf;
            int ra;
            wrap = (m == 1);
            cf = call && ret;
            ov = call && !ret && mLvl[m] == D;
            un = ret && !call && mLvl[m] == 0;
            if (cf) begin
            end else if (ret) begin
                if (mLvl[m] > 0 || wrap) begin
                    mPtr[m] = (mPtr[m] + D - 1) % D;
                    mPc[m]  = mMem[m][mPtr[m]];
                    if (mLvl[m] > 0) mLvl[m]--;
                end
            end else if (call) begin
                ra = inc ? (mPc[m] + 1) % (1 << AW) : mPc[m];
                if (mLvl[m] < D || wrap) begin
                    mMem[m][mPtr[m]] = ra;
                    mPtr[m] = (mPtr[m] + 1) % D;
                    if (mLvl[m] < D) mLvl[m]++;
                end
                mPc[m] = int'(target);
            end else if (load) begin
                mPc[m] = int'(target);
            end else if (inc) begin
                mPc[m] = (mPc[m] + 1) % (1 << AW);
            end
            mOv[m] = (mOv[m] && !errClr) || ov;
            mUn[m] = (mUn[m] && !errClr) || un;
            mCf[m] = (mCf[m] && !errClr) || cf;
        end
    endtask

    task automatic checkAll(input string tag);
        for (int m = 0; m < 2; m++) begin
            string t;
            t = $sformatf("%s.m%0d", tag, m);
            chk({t, ".pc"},  32'(m ? pcW : pcS), 32'(mPc[m]));
            chk({t, ".top"}, 32'(m ? topW : topS),
                32'(mMem[m][(mPtr[m] + D - 1) % D]));
            chk({t, ".lvl"}, 32'(m ? lvlW : lvlS), 32'(mLvl[m]));
            chk({t, ".full"}, 32'(m ? fullW : fullS), 32'(mLvl[m] == D));
            chk({t, ".empty"}, 32'(m ? emptyW : emptyS), 32'(mLvl[m] == 0));
            chk({t, ".ov"}, 32'(m ? ovW : ovS), 32'(mOv[m]));
            chk({t, ".un"}, 32'(m ? unW : unS), 32'(mUn[m]));
            chk({t, ".cf"}, 32'(m ? cfW : cfS), 32'(mCf[m]));
        end
    endtask

    task automatic cycle(input string tag, input bit i, input bit l,
                         input bit c, input bit r, input int t,
                         input bit e);
        inc = i; load = l; call = c; ret = r; errClr = e;
        target = AW'(t);
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic asyncReset(input string tag);
        #2 rst = 1'b1;
        modelReset();
        #1 checkAll({tag, ".during"});
        @(posedge clk);
        #1 rst = 1'b0;
        inc = 0; load = 0; call = 0; ret = 0; errClr = 0;
        checkAll({tag, ".after"});
    endtask

    initial begin
        int expW[3];
        int expS[3];

        // reset held across a pending call
        modelReset();
        call = 1'b1; target = 12'h123;
        repeat (2) @(posedge clk);
        #1 checkAll("rst");
        rst = 1'b0; call = 1'b0;

        for (int k = 0; k < 5; k++) cycle("t1.inc", 1, 0, 0, 0, 0, 0);
        chk("t1.pc5", 32'(pcW), 32'h005);

        // reset asserted mid-call, off the clock edge
        cycle("t1.c", 0, 0, 1, 0, 12'h300, 0);
        inc = 0; load = 0; call = 1; ret = 0; target = 12'h400;
        asyncReset("t1.arst");
        chk("t1.arst.lvl", 32'(lvlW), 32'h0);

        cycle("t2.ld", 0, 1, 0, 0, 12'h0FF, 0);
        cycle("t2.call", 1, 0, 1, 0, 12'h200, 0);
        chk("t2.pc", 32'(pcW), 32'h200);
        chk("t2.top", 32'(topW), 32'h100);
        chk("t2.lvl", 32'(lvlS), 32'h1);
        cycle("t2.ret", 0, 0, 0, 1, 0, 0);
        chk("t2.retpc", 32'(pcS), 32'h100);
        chk("t2.empty", 32'(emptyW), 32'h1);

        cycle("t3.ld", 0, 1, 0, 0, 12'h010, 0);
        cycle("t3.c1", 0, 0, 1, 0, 12'h020, 0);
        cycle("t3.c2", 0, 0, 1, 0, 12'h030, 0);
        cycle("t3.c3", 0, 0, 1, 0, 12'h040, 0);
        cycle("t3.c4", 0, 0, 1, 0, 12'h050, 0);
        chk("t3.ovW", 32'(ovW), 32'h1);
        chk("t3.ovS", 32'(ovS), 32'h1);
        chk("t3.lvlW", 32'(lvlW), 32'h3);
        chk("t4.pcS", 32'(pcS), 32'h050);
        expW = '{12'h040, 12'h030, 12'h020};
        expS = '{12'h030, 12'h020, 12'h010};
        for (int k = 0; k < 3; k++) begin
            cycle("t3.ret", 0, 0, 0, 1, 0, 0);
            chk($sformatf("t3.retW%0d", k), 32'(pcW), 32'(expW[k]));
            chk($sformatf("t4.retS%0d", k), 32'(pcS), 32'(expS[k]));
        end

        cycle("t5.ret", 0, 0, 0, 1, 0, 0);
        chk("t5.pcS", 32'(pcS), 32'h010);
        chk("t5.unS", 32'(unS), 32'h1);
        cycle("t5.clr", 0, 0, 0, 0, 0, 1);
        chk("t5.clrS", 32'(unS), 32'h0);
        cycle("t5.clrerr", 0, 0, 0, 1, 0, 1);
        chk("t5.stickS", 32'(unS), 32'h1);

        cycle("t6.cr", 1, 1, 1, 1, 12'h777, 0);
        chk("t6.cf", 32'(cfW), 32'h1);
        cycle("t6.ldinc", 1, 1, 0, 0, 12'hABC, 0);
        chk("t6.pc", 32'(pcS), 32'hABC);

        cycle("wrap.ld", 0, 1, 0, 0, 12'hFFF, 0);
        cycle("wrap.inc", 1, 0, 0, 0, 0, 0);
        chk("wrap.pc", 32'(pcW), 32'h000);
        cycle("wrap.ld2", 0, 1, 0, 0, 12'hFFF, 0);
        cycle("wrap.call", 1, 0, 1, 0, 12'h123, 0);
        chk("wrap.top", 32'(topS), 32'h000);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                inc = 1'($urandom); call = 1'($urandom);
                ret = 1'($urandom); target = AW'($urandom);
                asyncReset("rnd.arst");
            end else begin
                int t;
                t = ($urandom_range(0, 7) == 0) ? 12'hFFE + $urandom_range(0, 1)
                                                : int'($urandom_range(0, 4095));
                cycle("rnd",
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0,
                      t,
                      $urandom_range(0, 9) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
